ula_seq: RTL
============

# ula_seq

Parametrised, handshaked successor to the datapath ALU (`ULA`).
- Register-to-register execution with configurable operand width.
- Adds XOR, shift and iterative multiply operations to the existing add, sub, and and or.
- Keeps the existing 4-bit `op` encodings and the `flags` layout, so `ULA_control` drives it unchanged.
- Sits in the execute stage. The core stalls on `in_ready`/`out_valid` instead of assuming single-cycle completion.

## Interface
- `WIDTH`, 64: operand/result width in bits; ≥ 8, power of two.
- `SHW`, $clog2(WIDTH): shift-amount width, taken from `b[SHW-1:0]`; derived, not overridden.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operands and op presented.
- `in_ready` out 1: block accepts; high only in IDLE.
- `a`, `b` in WIDTH: operands.
- `op` in 4: operation code.
- `out_valid` out 1: `result`/`flags` valid; held until `out_ready`.
- `out_ready` in 1: consumer takes result.
- `result` out WIDTH: registered result.
- `flags` out 4: [0] a==b, [1] result MSB, [2] overflow, [3] illegal op.

## Operation
- Op codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011.
  - SLL 0100, SRL 0101, SUB 0110, SRA 0111.
  - MUL 1000.
  - All other codes are illegal.
- States: IDLE, BUSY, DONE.
- IDLE → accept on `in_valid & in_ready`:
  - The block latches `a`, `b` and `op`.
  - Single-cycle ops compute and go to DONE.
  - MUL goes to BUSY with iteration count 0.
- BUSY (MUL only): shift-add, one multiplier bit per cycle, LSB first.
  - Accumulator is 2·WIDTH bits.
  - After WIDTH iterations → DONE.
- DONE: `out_valid`=1. `out_ready`=1 → IDLE at the next edge.
- Accept in DONE is not allowed, so peak throughput is one op per 2 cycles.
- Arithmetic is modulo 2^WIDTH.
- Shifts:
  - Amount is `b[SHW-1:0]`; upper bits of `b` are ignored.
  - SRA replicates `a[WIDTH-1]`.
- MUL:
  - Operands are unsigned; `result` is the low WIDTH bits.
  - flags[2] = 1 iff the high WIDTH bits are nonzero.
- flags[0]: `a==b` on the latched operands, for all ops.
- flags[1]: `result[WIDTH-1]`.
- flags[2] for ADD: a, b MSBs equal and result MSB differs from a.
- flags[2] for SUB: a, b MSBs differ and result MSB differs from a.
- flags[2] for logic/shift ops: 0.
- Illegal op: result 0, flags[3]=1, flags[2]=0. Still completes through DONE and never hangs.
- `in_valid` while busy is ignored and not queued. The producer holds it until `in_ready`.
- Inputs are sampled only at the accept edge. Later changes to `a`, `b` or `op` have no effect.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `flags`=0, iteration counter 0.
- Reset asserted mid-BUSY or in DONE aborts the op immediately (asynchronous). No result is delivered.
- Single-cycle ops:
  - Accepted at edge T.
  - `out_valid`=1 from T.
  - Earliest next accept at edge T+2, given `out_ready`=1 during cycle after T.
- MUL:
  - Accepted at edge T.
  - BUSY from T to T+WIDTH.
  - `out_valid`=1 from edge T+WIDTH.
  - With WIDTH=64: 64 cycles of latency.
- `out_ready` held low: `result`/`flags` stable, `out_valid` stays 1 indefinitely.
- `out_ready`=1 while `out_valid`=0 has no effect.
- `in_ready` is a function of state only, with no combinational path from `in_valid`/`out_ready`.

## Configuration
- `ULA_SEQ_MUL_EN` defined: MUL (1000) is implemented as above. Includes BUSY state, counter and 2·WIDTH accumulator.
- Not defined:
  - MUL is treated as an illegal op: single-cycle, result 0, flags[3]=1.
  - BUSY state, counter and accumulator are not synthesised.

## Test plan
- Reset mid-operation: MUL accepted, `rst` pulsed at cycle 10 → `out_valid`=0, `in_ready`=1 immediately, no stale result appears afterwards.
- ADD overflow, WIDTH=64:
  - Stimulus: a=0x7FFF_FFFF_FFFF_FFFF, b=1.
  - Result 0x8000_0000_0000_0000, flags=0110, `out_valid` one edge after accept.
- SUB equal, with backpressure:
  - Stimulus: a=b=5, `out_ready` low 3 cycles.
  - Result 0, flags=0001 held stable for 3 cycles.
  - `in_ready`=0 throughout; a new `in_valid` is not accepted.
- SRA then SLL:
  - SRA: a=0x8000_0000_0000_0000, b=0x43 (amount 3) → 0xF000_0000_0000_0000, flags[1]=1.
  - SLL: a=1, b=63 → 0x8000_0000_0000_0000.
- MUL, macro defined:
  - a=0xFFFF_FFFF, b=0x1_0000_0001 → result 0xFFFF_FFFF_FFFF_FFFF, flags[2]=0, `out_valid` exactly 64 edges after accept.
  - a=2^63, b=2 → result 0, flags[2]=1.
- Illegal op 1111, and 1000 with macro undefined → result 0, flags[3]=1, completes in one cycle, block returns to IDLE.

Source files
------------

// File: rtl/ula_seq.sv
// ula_seq: handshaked, register-to-register ALU for the execute stage.
// Optional iterative multiplier is enabled by defining ULA_SEQ_MUL_EN.
module ula_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;

`ifdef ULA_SEQ_MUL_EN
    localparam logic [3:0]     OP_MUL = 4'b1000;
    localparam logic [SHW-1:0] LAST   = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t state, next_state;

    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             sc_ovf;
    logic             sc_illegal;
    logic [3:0]       sc_flags;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Single-cycle ops evaluate straight off the inputs so the result is
    // captured on the accept edge itself.
    always_comb begin
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        sum        = a + b;
        diff       = a - b;
        shamt      = b[SHW-1:0];
        case (op)
            OP_AND: sc_result = a & b;
            OP_OR:  sc_result = a | b;
            OP_XOR: sc_result = a ^ b;
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL: sc_result = a << shamt;
            OP_SRL: sc_result = a >> shamt;
            OP_SRA: sc_result = $signed(a) >>> shamt;
`ifdef ULA_SEQ_MUL_EN
            OP_MUL: sc_result = '0;
`endif
            default: sc_illegal = 1'b1;
        endcase
        sc_flags = {sc_illegal, sc_ovf, sc_result[WIDTH-1], (a == b)};
    end

`ifdef ULA_SEQ_MUL_EN
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               eq_q;
    logic [2*WIDTH-1:0] acc_next;
    logic               is_mul;

    assign is_mul   = (op == OP_MUL);
    assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef ULA_SEQ_MUL_EN
                    next_state = is_mul ? BUSY : DONE;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef ULA_SEQ_MUL_EN
            BUSY: if (cnt == LAST) next_state = DONE;
`endif
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result/flags only move on accept or on the final multiply step, so they
    // hold steady for as long as the consumer stalls in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
`ifdef ULA_SEQ_MUL_EN
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            eq_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ULA_SEQ_MUL_EN
                        if (is_mul) begin
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                            eq_q   <= (a == b);
                        end else begin
                            result <= sc_result;
                            flags  <= sc_flags;
                        end
`else
                        result <= sc_result;
                        flags  <= sc_flags;
`endif
                    end
                end
`ifdef ULA_SEQ_MUL_EN
                // Shift-add, multiplier LSB first; the last step writes the
                // low half out and flags any bits left in the high half.
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result <= acc_next[WIDTH-1:0];
                        flags  <= {1'b0, |acc_next[2*WIDTH-1:WIDTH], acc_next[WIDTH-1], eq_q};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
